// File: rtl/bt_at_config.sv
// HC-05 AT power-up sequencer: streams a zero-terminated command table into the UART TX and waits for
// "OK\r\n" per command with timeout and bounded retry; define BT_AT_ERROR_DETECT_EN to fast-fail on "ERROR".
module bt_at_config #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              uart_ready,
  output logic              uart_send,
  output logic [7:0]        uart_data,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        cmd_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_TXGAP     = 3'd2;
  localparam logic [2:0] S_WAIT_TX   = 3'd3;
  localparam logic [2:0] S_WAIT_RESP = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;
  localparam logic [2:0] S_FAIL      = 3'd6;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d, cmd_base_q, cmd_base_d;
  logic              uart_send_q, uart_send_d;
  logic [7:0]        uart_data_q, uart_data_d;
  logic              done_q, done_d, fail_q, fail_d;
  logic [7:0]        cmd_count_q, cmd_count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [1:0]        ok_idx_q, ok_idx_d;
  logic              ok_seen_q, ok_seen_d;
  logic              active, restart, err_now;
`ifdef BT_AT_ERROR_DETECT_EN
  logic [2:0]        err_idx_q, err_idx_d;
  logic              err_seen_q, err_seen_d;

  function automatic logic [7:0] err_char(input logic [2:0] i);
    case (i)
      3'd0:    err_char = 8'h45;
      3'd3:    err_char = 8'h4F;
      default: err_char = 8'h52;
    endcase
  endfunction
`endif

  function automatic logic [7:0] ok_char(input logic [1:0] i);
    case (i)
      2'd0:    ok_char = 8'h4F;
      2'd1:    ok_char = 8'h4B;
      2'd2:    ok_char = 8'h0D;
      default: ok_char = 8'h0A;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    cmd_base_d  = cmd_base_q;
    uart_send_d = 1'b0;
    uart_data_d = uart_data_q;
    done_d      = done_q;
    fail_d      = fail_q;
    cmd_count_d = cmd_count_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    ok_idx_d    = ok_idx_q;
    ok_seen_d   = ok_seen_q;
    restart     = 1'b0;
    err_now     = 1'b0;
    active      = (state_q == S_FETCH) || (state_q == S_TXGAP) ||
                  (state_q == S_WAIT_TX) || (state_q == S_WAIT_RESP);

    // Response matchers; a mismatching lead character re-arms at index 1.
    if (active && rx_valid) begin
      if (rx_data == ok_char(ok_idx_q)) begin
        ok_idx_d = ok_idx_q + 2'd1;
        if (ok_idx_q == 2'd3) ok_seen_d = 1'b1;
      end else begin
        ok_idx_d = (rx_data == 8'h4F) ? 2'd1 : 2'd0;
      end
    end
`ifdef BT_AT_ERROR_DETECT_EN
    err_idx_d  = err_idx_q;
    err_seen_d = err_seen_q;
    if (active && rx_valid) begin
      if (rx_data == err_char(err_idx_q)) begin
        err_idx_d = (err_idx_q == 3'd4) ? 3'd0 : err_idx_q + 3'd1;
        if (err_idx_q == 3'd4) err_seen_d = 1'b1;
      end else begin
        err_idx_d = (rx_data == 8'h45) ? 3'd1 : 3'd0;
      end
    end
    err_now = err_seen_d;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          done_d      = 1'b0;
          fail_d      = 1'b0;
          cmd_count_d = 8'd0;
          rom_addr_d  = '0;
          cmd_base_d  = '0;
          retry_d     = '0;
          restart     = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rom_data == 8'h00) begin
          if (rom_addr_q == cmd_base_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            tmo_d   = '0;
            state_d = S_WAIT_RESP;
          end
        end else if (uart_ready) begin
          uart_send_d = 1'b1;
          uart_data_d = rom_data;
          state_d     = S_TXGAP;
        end
      end
      // The UART only drops ready the cycle after the strobe, so skip one cycle before polling it.
      S_TXGAP: state_d = S_WAIT_TX;
      S_WAIT_TX: begin
        if (uart_ready) begin
          rom_addr_d = rom_addr_q + 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_WAIT_RESP: begin
        tmo_d = tmo_q + 1'b1;
        if (ok_seen_d) begin
          if (cmd_count_q != 8'hFF) cmd_count_d = cmd_count_q + 8'd1;
          retry_d    = '0;
          cmd_base_d = rom_addr_q + 1'b1;
          rom_addr_d = rom_addr_q + 1'b1;
          restart    = 1'b1;
          state_d    = S_FETCH;
        end else if ((tmo_q == TMO_LAST) || err_now) begin
          if (retry_q < RETRY_MAX) begin
            retry_d    = retry_q + 1'b1;
            rom_addr_d = cmd_base_q;
            restart    = 1'b1;
            state_d    = S_FETCH;
          end else begin
            fail_d  = 1'b1;
            state_d = S_FAIL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      ok_idx_d  = 2'd0;
      ok_seen_d = 1'b0;
`ifdef BT_AT_ERROR_DETECT_EN
      err_idx_d  = 3'd0;
      err_seen_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      cmd_base_q  <= '0;
      uart_send_q <= 1'b0;
      uart_data_q <= 8'd0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      cmd_count_q <= 8'd0;
      tmo_q       <= '0;
      retry_q     <= '0;
      ok_idx_q    <= 2'd0;
      ok_seen_q   <= 1'b0;
`ifdef BT_AT_ERROR_DETECT_EN
      err_idx_q   <= 3'd0;
      err_seen_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      cmd_base_q  <= cmd_base_d;
      uart_send_q <= uart_send_d;
      uart_data_q <= uart_data_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      cmd_count_q <= cmd_count_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      ok_idx_q    <= ok_idx_d;
      ok_seen_q   <= ok_seen_d;
`ifdef BT_AT_ERROR_DETECT_EN
      err_idx_q   <= err_idx_d;
      err_seen_q  <= err_seen_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign uart_send = uart_send_q;
  assign uart_data = uart_data_q;
  assign busy      = active;
  assign done      = done_q;
  assign fail      = fail_q;
  assign cmd_count = cmd_count_q;

endmodule
